// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Purpose  : Shared opcodes, state encoding and mux codes for the RISC control unit.
// Revision : 1.0 - initial release
// ============================================================================
package risc_pkg;

   localparam int OPC_W = 4;
   localparam int RA_W  = 4;
   localparam int AW    = 8;

   localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
   localparam logic [OPC_W-1:0] OP_LDI   = 4'h2;
   localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
   localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
   localparam logic [OPC_W-1:0] OP_STORE = 4'h5;
   localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

   localparam logic [1:0] RF_SRC_ALU = 2'd0;
   localparam logic [1:0] RF_SRC_MEM = 2'd1;
   localparam logic [1:0] RF_SRC_IMM = 2'd2;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_FETCH_W = 3'd2,
      ST_DECODE  = 3'd3,
      ST_MEM_RD  = 3'd4,
      ST_WB      = 3'd5,
      ST_MEM_WR  = 3'd6,
      ST_HALT    = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/risc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : risc_control_unit_if
// Purpose  : Control bus between the control unit (master) and the datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface risc_control_unit_if;
   import risc_pkg::*;

   logic [15:0]     ir_out;
   logic            pc_ld;
   logic            pc_inc;
   logic            pc_clr;
   logic            ir_ld;
   logic            ir_rst;
   logic            data_addr_sel;
   logic            rd;
   logic            wr;
   logic [1:0]      rf_sel;
   logic [2:0]      alu_sel;
   logic [RA_W-1:0] wr_addr;
   logic [RA_W-1:0] rd_addr_P;
   logic [RA_W-1:0] rd_addr_Q;
   logic            w_wr;
   logic            rd_P;
   logic            rd_Q;
   logic            rst16x16;
   logic            halted;
   logic            illegal;
   logic [2:0]      state;

   modport master (
      input  ir_out,
      output pc_ld, pc_inc, pc_clr, ir_ld, ir_rst, data_addr_sel, rd, wr,
             rf_sel, alu_sel, wr_addr, rd_addr_P, rd_addr_Q,
             w_wr, rd_P, rd_Q, rst16x16, halted, illegal, state
   );

   modport slave (
      output ir_out,
      input  pc_ld, pc_inc, pc_clr, ir_ld, ir_rst, data_addr_sel, rd, wr,
             rf_sel, alu_sel, wr_addr, rd_addr_P, rd_addr_Q,
             w_wr, rd_P, rd_Q, rst16x16, halted, illegal, state
   );

endinterface
`default_nettype wire

// File: rtl/risc_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : risc_op_decode
// Purpose  : Combinational opcode classifier for the RISC control unit.
// Revision : 1.0 - initial release
// ============================================================================
module risc_op_decode
   import risc_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             is_load,
   output logic             is_ldi,
   output logic             is_alu,
   output logic             is_store,
   output logic             is_halt,
   output logic             is_illegal
);

   always_comb begin
      is_load    = 1'b0;
      is_ldi     = 1'b0;
      is_alu     = 1'b0;
      is_store   = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_NOP:         ;
         OP_LOAD:        is_load  = 1'b1;
         OP_LDI:         is_ldi   = 1'b1;
         OP_ADD, OP_SUB: is_alu   = 1'b1;
         OP_STORE:       is_store = 1'b1;
         OP_HALT:        is_halt  = 1'b1;
         default:        is_illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/risc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : risc_control_unit
// Purpose  : Multi-cycle fetch/decode/execute FSM driving the 16-bit RISC datapath.
//            Optional: RISC_SINGLE_STEP_EN adds a step input gating FETCH.
// Revision : 1.0 - initial release
// ============================================================================
module risc_control_unit
   import risc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
`ifdef RISC_SINGLE_STEP_EN
   input  logic                step,
`endif
   risc_control_unit_if.master bus
);

   state_t          r_state;
   state_t          w_next_state;
   logic [OPC_W-1:0] w_opcode;
   logic [RA_W-1:0]  w_rx;
   logic [RA_W-1:0]  w_rp;
   logic [RA_W-1:0]  w_rq;
   logic            w_is_load;
   logic            w_is_ldi;
   logic            w_is_alu;
   logic            w_is_store;
   logic            w_is_halt;
   logic            w_is_illegal;
   logic            w_fetch_go;

   assign w_opcode = bus.ir_out[15:12];
   assign w_rx     = bus.ir_out[11:8];
   assign w_rp     = bus.ir_out[7:4];
   assign w_rq     = bus.ir_out[3:0];

`ifdef RISC_SINGLE_STEP_EN
   assign w_fetch_go = step;
`else
   assign w_fetch_go = 1'b1;
`endif

   risc_op_decode u_op_decode (
      .opcode     (w_opcode),
      .is_load    (w_is_load),
      .is_ldi     (w_is_ldi),
      .is_alu     (w_is_alu),
      .is_store   (w_is_store),
      .is_halt    (w_is_halt),
      .is_illegal (w_is_illegal)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_INIT;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state      = r_state;
      bus.pc_ld         = 1'b0;
      bus.pc_inc        = 1'b0;
      bus.pc_clr        = 1'b0;
      bus.ir_ld         = 1'b0;
      bus.ir_rst        = 1'b0;
      bus.data_addr_sel = 1'b0;
      bus.rd            = 1'b0;
      bus.wr            = 1'b0;
      bus.rf_sel        = RF_SRC_ALU;
      bus.alu_sel       = ALU_ADD;
      bus.wr_addr       = '0;
      bus.rd_addr_P     = '0;
      bus.rd_addr_Q     = '0;
      bus.w_wr          = 1'b0;
      bus.rd_P          = 1'b0;
      bus.rd_Q          = 1'b0;
      bus.rst16x16      = 1'b0;
      bus.halted        = 1'b0;
      bus.illegal       = 1'b0;
      bus.state         = r_state;
      case (r_state)
         ST_INIT: begin
            bus.pc_clr   = 1'b1;
            bus.ir_rst   = 1'b1;
            bus.rst16x16 = 1'b1;
            w_next_state = ST_FETCH;
         end
         // RAM registers mem[PC] on the edge that leaves FETCH.
         ST_FETCH: begin
            bus.rd = w_fetch_go;
            if (w_fetch_go) w_next_state = ST_FETCH_W;
         end
         ST_FETCH_W: begin
            bus.rd       = 1'b1;
            bus.ir_ld    = 1'b1;
            bus.pc_inc   = 1'b1;
            w_next_state = ST_DECODE;
         end
         ST_DECODE: begin
            bus.rd_P    = 1'b1;
            bus.rd_Q    = 1'b1;
            bus.illegal = w_is_illegal;
            if (w_is_load)                 w_next_state = ST_MEM_RD;
            else if (w_is_ldi || w_is_alu) w_next_state = ST_WB;
            else if (w_is_store)           w_next_state = ST_MEM_WR;
            else if (w_is_halt)            w_next_state = ST_HALT;
            else                           w_next_state = ST_FETCH;
         end
         ST_MEM_RD: begin
            bus.data_addr_sel = 1'b1;
            bus.rd            = 1'b1;
            w_next_state      = ST_WB;
         end
         ST_WB: begin
            bus.w_wr     = 1'b1;
            w_next_state = ST_FETCH;
            if (w_is_load) begin
               bus.data_addr_sel = 1'b1;
               bus.rf_sel        = RF_SRC_MEM;
               bus.wr_addr       = w_rx;
            end else if (w_is_ldi) begin
               bus.rf_sel  = RF_SRC_IMM;
               bus.wr_addr = w_rx;
            end else begin
               bus.rf_sel    = RF_SRC_ALU;
               bus.alu_sel   = (w_opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
               bus.rd_addr_P = w_rp;
               bus.rd_addr_Q = w_rq;
            end
         end
         ST_MEM_WR: begin
            bus.data_addr_sel = 1'b1;
            bus.wr            = 1'b1;
            bus.rd_addr_P     = w_rx;
            w_next_state      = ST_FETCH;
         end
         ST_HALT: begin
            bus.halted = 1'b1;
         end
         default: w_next_state = ST_INIT;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_risc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_control_unit
// Purpose  : Self-checking bench: per-cycle control outputs vs an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_control_unit;

   typedef struct packed {
      logic       pc_ld, pc_inc, pc_clr, ir_ld, ir_rst, das, rd, wr;
      logic [1:0] rf_sel;
      logic [2:0] alu_sel;
      logic [3:0] wr_addr, rd_addr_P, rd_addr_Q;
      logic       w_wr, rd_P, rd_Q, rst16x16, halted, illegal;
      logic [2:0] state;
   } ctl_t;

   typedef struct {
      logic [15:0] ir;
      int          len;
      int          ill;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        step;
   logic [15:0] r_ir;
   logic [15:0] r_next_instr;
   int          total;
   int          bad;

   risc_control_unit_if bus ();

   risc_control_unit dut (
      .clk  (clk),
      .rst  (rst),
`ifdef RISC_SINGLE_STEP_EN
      .step (step),
`endif
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Minimal IR model standing in for the datapath.
   always @(posedge clk or negedge rst) begin
      if (!rst)            r_ir <= '0;
      else if (bus.ir_rst) r_ir <= '0;
      else if (bus.ir_ld)  r_ir <= r_next_instr;
   end
   assign bus.ir_out = r_ir;

   function automatic ctl_t sample();
      ctl_t s;
      s = '{bus.pc_ld, bus.pc_inc, bus.pc_clr, bus.ir_ld, bus.ir_rst, bus.data_addr_sel,
            bus.rd, bus.wr, bus.rf_sel, bus.alu_sel, bus.wr_addr, bus.rd_addr_P,
            bus.rd_addr_Q, bus.w_wr, bus.rd_P, bus.rd_Q, bus.rst16x16, bus.halted,
            bus.illegal, bus.state};
      return s;
   endfunction

   function automatic ctl_t exp_init();
      ctl_t e = '0;
      e.pc_clr = 1'b1; e.ir_rst = 1'b1; e.rst16x16 = 1'b1;
      return e;
   endfunction

   function automatic bit op_legal(input logic [3:0] op);
      return (op <= 4'h5) || (op == 4'hF);
   endfunction

   // Number of cycles from FETCH to the next FETCH for one instruction.
   function automatic int instr_len(input logic [15:0] ir);
      logic [3:0] op = ir[15:12];
      if (op == 4'h1) return 5;
      if (op >= 4'h2 && op <= 4'h5) return 4;
      return 3;
   endfunction

   // Expected outputs in cycle k of an instruction (k = 0 is its FETCH).
   function automatic ctl_t exp_cycle(input logic [15:0] ir, input int k);
      ctl_t e = '0;
      logic [3:0] op = ir[15:12];
      if (k == 0) begin
         e.state = 3'd1; e.rd = 1'b1;
      end else if (k == 1) begin
         e.state = 3'd2; e.rd = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
      end else if (k == 2) begin
         e.state = 3'd3; e.rd_P = 1'b1; e.rd_Q = 1'b1; e.illegal = !op_legal(op);
      end else if (op == 4'hF) begin
         e.state = 3'd7; e.halted = 1'b1;
      end else if (op == 4'h1 && k == 3) begin
         e.state = 3'd4; e.das = 1'b1; e.rd = 1'b1;
      end else if (op == 4'h5) begin
         e.state = 3'd6; e.das = 1'b1; e.wr = 1'b1; e.rd_addr_P = ir[11:8];
      end else begin
         e.state = 3'd5; e.w_wr = 1'b1;
         if (op == 4'h1) begin
            e.das = 1'b1; e.rf_sel = 2'd1; e.wr_addr = ir[11:8];
         end else if (op == 4'h2) begin
            e.rf_sel = 2'd2; e.wr_addr = ir[11:8];
         end else begin
            e.alu_sel = (op == 4'h4) ? 3'd1 : 3'd0;
            e.rd_addr_P = ir[7:4]; e.rd_addr_Q = ir[3:0];
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input ctl_t exp);
      ctl_t act = sample();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Called at a negedge with the DUT in FETCH; returns at a negedge nchk cycles later.
   task automatic run_instr(input logic [15:0] ir, input int nchk, output int ill_cnt);
      r_next_instr = ir;
      ill_cnt = 0;
      for (int k = 0; k < nchk; k++) begin
         check($sformatf("ir%04h_c%0d", ir, k), exp_cycle(ir, k));
         if (bus.illegal) ill_cnt++;
         @(negedge clk);
      end
   endtask

   // rst is already low; hold, release, and end at a negedge in FETCH.
   task automatic reset_tail(input string name);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({name, "_hold"}, exp_init());
      end
      rst = 1'b1;
      #1 check({name, "_after"}, exp_init());
      @(negedge clk);
   endtask

   vec_t vecs[$];
   int   ill;

   initial begin
      total = 0; bad = 0;
      step = 1'b1;
      r_next_instr = '0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1 check("reset_async", exp_init());
      reset_tail("reset");

`ifdef RISC_SINGLE_STEP_EN
      step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ctl_t e = '0;
         e.state = 3'd1;
         check("step_hold", e);
         @(negedge clk);
      end
      step = 1'b1;
`endif

      vecs = '{
         '{16'h2105, 4, 0}, '{16'h121F, 5, 0}, '{16'h3013, 4, 0},
         '{16'h4013, 4, 0}, '{16'h5136, 4, 0}, '{16'h7000, 3, 1},
         '{16'h0000, 3, 0}, '{16'hE123, 3, 1}, '{16'h6ABC, 3, 1},
         '{16'h4FED, 4, 0}
      };
      foreach (vecs[i]) begin
         run_instr(vecs[i].ir, vecs[i].len, ill);
         check_int($sformatf("illegal_cnt_%04h", vecs[i].ir), ill, vecs[i].ill);
         check_int($sformatf("len_%04h", vecs[i].ir), int'(bus.state), 1);
      end

      for (int n = 0; n < 150; n++) begin
         logic [15:0] ir;
         ir = 16'($urandom());
         if (ir[15:12] == 4'hF) ir[15:12] = 4'h3;
         run_instr(ir, instr_len(ir), ill);
         check_int("rand_illegal", ill, op_legal(ir[15:12]) ? 0 : 1);
      end

      // Reset in the WB cycle of an ADD: write strobe must vanish at once.
      r_next_instr = 16'h3013;
      for (int k = 0; k < 3; k++) begin
         check("add_pre", exp_cycle(16'h3013, k));
         @(negedge clk);
      end
      check("add_wb", exp_cycle(16'h3013, 3));
      #1 rst = 1'b0;
      #1 check("rst_mid_wb", exp_init());
      reset_tail("rst_wb");

      // HALT holds until reset with no strobes.
      run_instr(16'hF000, 9, ill);
      check_int("halt_illegal", ill, 0);
      rst = 1'b0;
      #1 check("halt_exit_rst", exp_init());
      reset_tail("halt_rst");
      run_instr(16'h2A7C, 4, ill);
      check("post_halt_fetch", exp_cycle(16'h0000, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
